if_stage: RTL and testbench



---
 rtl/if_stage.sv | 129 ++++++++++++
 tb/tb_if_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the fetch PC, issues in-order imem requests,
// buffers returned words and drives the IF/ID register feeding decode.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 2,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        stall_flag,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] pc_out,
   output logic [31:0] inst_out,
   output logic        id_valid
);

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = $clog2(QDEPTH + 1);
   localparam logic [CW:0] QCAP = QDEPTH[CW:0];

   logic [31:0]   fetch_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] discard;
   logic [CW-1:0] qcount;
   logic [PW-1:0] q_rd, q_wr;
   logic [PW-1:0] t_rd, t_wr;
   logic [31:0]   q_pc   [QDEPTH];
   logic [31:0]   q_inst [QDEPTH];
   logic [31:0]   tag_pc [QDEPTH];

   logic [CW:0]   in_use;
   logic [31:0]   redir_target;
   logic          issue;
   logic          resp_live;
   logic          q_empty;
   logic          pop;
   logic          bypass;
   logic          push;

   // Queued words plus in-flight requests never exceed the queue depth,
   // so a stalled decoder can never cause an overflow.
   assign in_use         = {1'b0, qcount} + {1'b0, outstanding};
   assign imem_req_valid = !rst && !redirect_valid && (in_use < QCAP);
   assign imem_req_addr  = fetch_pc;
   assign redir_target   = redirect_pc & ~32'h3;

   assign issue     = imem_req_valid && imem_req_ready;
   assign resp_live = imem_resp_valid && !redirect_valid
                      && (discard == '0);
   assign q_empty   = (qcount == '0);
   assign pop       = !redirect_valid && !stall_flag && !q_empty;
   assign bypass    = !redirect_valid && !stall_flag && q_empty
                      && resp_live;
   assign push      = resp_live && !bypass;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
         qcount      <= '0;
         q_rd        <= '0;
         q_wr        <= '0;
         t_rd        <= '0;
         t_wr        <= '0;
         pc_out      <= RESET_PC;
         inst_out    <= NOP_INST;
         id_valid    <= 1'b0;
      end else begin
         outstanding <= outstanding + CW'(issue) - CW'(imem_resp_valid);
         if (redirect_valid) begin
            // Everything still in flight belongs to the old path.
            fetch_pc <= redir_target;
            discard  <= outstanding - CW'(imem_resp_valid);
            qcount   <= '0;
            q_rd     <= '0;
            q_wr     <= '0;
            t_rd     <= '0;
            t_wr     <= '0;
            inst_out <= NOP_INST;
            id_valid <= 1'b0;
         end else begin
            if (issue) begin
               fetch_pc <= fetch_pc + 32'd4;
               t_wr     <= t_wr + 1'b1;
            end
            if (imem_resp_valid && discard != '0)
               discard <= discard - 1'b1;
            if (resp_live)
               t_rd <= t_rd + 1'b1;
            if (push)
               q_wr <= q_wr + 1'b1;
            if (pop)
               q_rd <= q_rd + 1'b1;
            qcount <= qcount + CW'(push) - CW'(pop);
            if (!stall_flag) begin
               if (pop) begin
                  pc_out   <= q_pc[q_rd];
                  inst_out <= q_inst[q_rd];
                  id_valid <= 1'b1;
               end else if (bypass) begin
                  pc_out   <= tag_pc[t_rd];
                  inst_out <= imem_resp_data;
                  id_valid <= 1'b1;
               end else begin
                  inst_out <= NOP_INST;
                  id_valid <= 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (issue)
         tag_pc[t_wr] <= fetch_pc;
      if (push) begin
         q_pc[q_wr]   <= tag_pc[t_rd];
         q_inst[q_wr] <= imem_resp_data;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: in-order memory model plus an
// architectural fetch-sequence model checked every cycle.
module tb_if_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data  = '0;
   logic        stall_flag;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] pc_out;
   logic [31:0] inst_out;
   logic        id_valid;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   int mem_lat;

   typedef struct {
      logic [31:0] a;
      int          due;
   } mreq_t;
   mreq_t mq[$];

   if_stage dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data (imem_resp_data),
      .stall_flag     (stall_flag),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .pc_out         (pc_out),
      .inst_out       (inst_out),
      .id_valid       (id_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return (a | 32'h3) ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string n, input logic [31:0] got,
                      input logic [31:0] want);
      total++;
      if (got === want) passed++;
      else $display("FAIL %s: got %h want %h", n, got, want);
   endtask

   task automatic nxt;
      @(posedge clk);
      #2;
   endtask

   // In-order instruction memory with programmable latency
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = word_at(mq[0].a);
      end else begin
         imem_resp_valid = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         mq.delete();
      end else begin
         if (imem_resp_valid && mq.size() > 0) void'(mq.pop_front());
         if (imem_req_valid && imem_req_ready)
            mq.push_back('{a: imem_req_addr, due: cyc + mem_lat});
      end
   end

   // Architectural model: valid IF/ID entries must walk the program
   // order from the last reset/redirect target; requests likewise.
   logic [31:0] exp_pc, exp_req, p_pc, p_inst;
   logic        p_v, p_redir, p_stall;
   initial begin
      p_redir = 1'b0;
      p_stall = 1'b0;
      exp_pc  = RESET_PC;
      exp_req = RESET_PC;
   end

   always @(negedge clk) begin
      if (rst) begin
         chk("m_rst_pc", pc_out, RESET_PC);
         chk("m_rst_inst", inst_out, NOP);
         chk("m_rst_idv", {31'b0, id_valid}, 32'd0);
         chk("m_rst_req", {31'b0, imem_req_valid}, 32'd0);
         exp_pc  = RESET_PC;
         exp_req = RESET_PC;
         p_redir = 1'b0;
         p_stall = 1'b0;
      end else begin
         if (p_redir) begin
            chk("m_redir_idv", {31'b0, id_valid}, 32'd0);
            chk("m_redir_inst", inst_out, NOP);
            chk("m_redir_pc", pc_out, p_pc);
         end else if (p_stall) begin
            chk("m_stall_pc", pc_out, p_pc);
            chk("m_stall_inst", inst_out, p_inst);
            chk("m_stall_idv", {31'b0, id_valid}, {31'b0, p_v});
         end else if (id_valid) begin
            chk("m_pc", pc_out, exp_pc);
            chk("m_inst", inst_out, word_at(exp_pc));
            exp_pc = exp_pc + 32'd4;
         end else begin
            chk("m_bub_inst", inst_out, NOP);
            chk("m_bub_pc", pc_out, p_pc);
         end
         if (redirect_valid) begin
            chk("m_redir_noreq", {31'b0, imem_req_valid}, 32'd0);
            exp_req = redirect_pc & ~32'h3;
            exp_pc  = exp_req;
         end else if (imem_req_valid) begin
            chk("m_req_addr", imem_req_addr, exp_req);
            if (imem_req_ready) exp_req = exp_req + 32'd4;
         end
         p_redir = redirect_valid;
         p_stall = stall_flag;
      end
      p_pc   = pc_out;
      p_inst = inst_out;
      p_v    = id_valid;
   end

   initial begin
      bit found;
      rst            = 1'b1;
      imem_req_ready = 1'b1;
      stall_flag     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      mem_lat        = 1;
      nxt; nxt;
      @(negedge clk);
      chk("reset_inst", inst_out, 32'h0000_0013);
      // streaming from reset, 1-cycle memory
      nxt; rst = 1'b0;
      @(negedge clk);
      chk("c0_req", {31'b0, imem_req_valid}, 32'd1);
      chk("c0_addr", imem_req_addr, 32'h0);
      nxt; @(negedge clk);
      chk("c1_addr", imem_req_addr, 32'h4);
      chk("c1_idv", {31'b0, id_valid}, 32'd0);
      nxt; @(negedge clk);
      chk("c2_idv", {31'b0, id_valid}, 32'd1);
      chk("c2_pc", pc_out, 32'h0);
      chk("c2_inst", inst_out, 32'hC0DE_0003);
      nxt; @(negedge clk);
      chk("c3_inst", inst_out, 32'hC0DE_0007);
      nxt; nxt;
      // stall for three cycles
      nxt; stall_flag = 1'b1;
      @(negedge clk);
      chk("c6_pc", pc_out, 32'h10);
      nxt; @(negedge clk);
      chk("c7_pc", pc_out, 32'h10);
      nxt; @(negedge clk);
      chk("c8_cap", {31'b0, imem_req_valid}, 32'd0);
      nxt; stall_flag = 1'b0;
      @(negedge clk);
      chk("c9_pc", pc_out, 32'h10);
      nxt; @(negedge clk);
      chk("c10_pc", pc_out, 32'h14);
      chk("c10_addr", imem_req_addr, 32'h1C);
      nxt; @(negedge clk);
      chk("c11_pc", pc_out, 32'h18);
      nxt; @(negedge clk);
      chk("c12_pc", pc_out, 32'h1C);
      // memory not ready for four cycles
      nxt; imem_req_ready = 1'b0;
      @(negedge clk);
      chk("c13_addr", imem_req_addr, 32'h28);
      nxt; nxt; nxt;
      @(negedge clk);
      chk("c16_addr", imem_req_addr, 32'h28);
      chk("c16_req", {31'b0, imem_req_valid}, 32'd1);
      nxt; imem_req_ready = 1'b1;
      repeat (5) nxt;
      // reset pulse mid-stream, then 3-cycle memory
      rst = 1'b1; mem_lat = 3;
      @(negedge clk);
      chk("rp_pc", pc_out, 32'h0);
      chk("rp_idv", {31'b0, id_valid}, 32'd0);
      nxt; rst = 1'b0;
      @(negedge clk);
      chk("r0_addr", imem_req_addr, 32'h0);
      nxt; @(negedge clk);
      chk("r1_addr", imem_req_addr, 32'h4);
      nxt; redirect_valid = 1'b1; redirect_pc = 32'h103;
      @(negedge clk);
      chk("r2_noreq", {31'b0, imem_req_valid}, 32'd0);
      nxt; redirect_valid = 1'b0;
      @(negedge clk);
      chk("r3_inst", inst_out, 32'h13);
      chk("r3_noreq", {31'b0, imem_req_valid}, 32'd0);
      nxt; @(negedge clk);
      chk("r4_addr", imem_req_addr, 32'h100);
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         nxt; @(negedge clk);
         if (id_valid) found = 1'b1;
      end
      chk("redir_found", {31'b0, found}, 32'd1);
      chk("redir_pc", pc_out, 32'h100);
      chk("redir_inst", inst_out, 32'hC0DE_0103);
      repeat (3) nxt;
      mem_lat = 1;
      repeat (8) nxt;
      // redirect and stall together, then PC wrap
      nxt; stall_flag = 1'b1; redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      @(negedge clk);
      chk("t0_noreq", {31'b0, imem_req_valid}, 32'd0);
      nxt; stall_flag = 1'b0; redirect_valid = 1'b0;
      @(negedge clk);
      chk("t1_idv", {31'b0, id_valid}, 32'd0);
      chk("t1_inst", inst_out, 32'h13);
      chk("t1_addr", imem_req_addr, 32'hFFFF_FFF8);
      nxt; @(negedge clk);
      chk("t2_addr", imem_req_addr, 32'hFFFF_FFFC);
      nxt; @(negedge clk);
      chk("t3_addr", imem_req_addr, 32'h0);
      chk("t3_pc", pc_out, 32'hFFFF_FFF8);
      chk("t3_inst", inst_out, 32'h3F21_FFFB);
      nxt; @(negedge clk);
      chk("t4_inst", inst_out, 32'h3F21_FFFF);
      nxt; @(negedge clk);
      chk("t5_pc", pc_out, 32'h0);
      chk("t5_inst", inst_out, 32'hC0DE_0003);
      repeat (4) nxt;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
